fix_sat_arb: RTL and testbench

Round-robin scheduler that shares a single fixed-point saturating narrowing unit among N requesters. Each requester presents IN_WIDTH two's-complement words on a valid/ready port. The block grants one word per cycle, narrows it to OUT_WIDTH with saturation, and returns the result after a fixed pipeline delay, tagged with the requester index. It sits between accumulators (multiply/accumulate outputs) and narrower storage or output datapaths. It also keeps per-requester saturation statistics.

---
 rtl/fix_sat_pkg.sv | 40 ++++
 rtl/fix_sat_arb_rr_arb.sv | 45 ++++
 rtl/fix_sat_arb.sv | 136 +++++++++++++
 tb/tb_fix_sat_arb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fix_sat_pkg.sv
// Shared constants and helpers for the saturating narrowing scheduler.
package fix_sat_pkg;

  // Widest word the helper functions handle. Callers zero-extend to this width.
  localparam int MAX_W = 64;

  // Most positive OUT_WIDTH-bit two's-complement value: 0 followed by ones.
  function automatic logic [MAX_W-1:0] SAT_MAX(input int ow);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int b = 0; b < MAX_W; b++)
      if (b < ow - 1) v[b] = 1'b1;
    return v;
  endfunction

  // Most negative OUT_WIDTH-bit two's-complement value: 1 followed by zeros.
  function automatic logic [MAX_W-1:0] SAT_MIN(input int ow);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int b = 0; b < MAX_W; b++)
      if (b == ow - 1) v[b] = 1'b1;
    return v;
  endfunction

  // Overflow when the bits that are dropped plus the new sign bit,
  // d[iw-1:ow-1], are neither all ones nor all zeros.
  function automatic logic ovf_det(input logic [MAX_W-1:0] d, input int iw, input int ow);
    logic any1, all1;
    any1 = 1'b0;
    all1 = 1'b1;
    for (int b = 0; b < MAX_W; b++) begin
      if (b >= ow - 1 && b < iw) begin
        any1 = any1 | d[b];
        all1 = all1 & d[b];
      end
    end
    return any1 & ~all1;
  endfunction

endpackage

// File: rtl/fix_sat_arb_rr_arb.sv
// N-wide round-robin arbiter: one-hot grant to the first requester at or
// after rr_ptr, with the pointer moving past the winner on each transfer.
module rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  int            idx;

  // Search upward from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    grant = '0;
    gidx  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(rr_ptr) + off) % N;
      if (en && req[idx] && !found) begin
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
        found      = 1'b1;
      end
    end
    ptr_nxt = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
  end

  // Pointer moves only when the granted word was actually taken.
  always_ff @(posedge clk) begin
    if (rst)          rr_ptr <= '0;
    else if (advance) rr_ptr <= ptr_nxt;
  end

endmodule

// File: rtl/fix_sat_arb.sv
// Round-robin shared saturating narrower with per-requester saturation stats.
module fix_sat_arb
  import fix_sat_pkg::*;
#(
  parameter int N         = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SAT_PIPE  = 1,
  parameter int CNT_W     = 8,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N-1:0]          req_valid,
  input  logic [N*IN_WIDTH-1:0] req_data,
  output logic [N-1:0]          req_ready,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  out_sat,
  output logic [N-1:0]          sat_flag,
  output logic [N*CNT_W-1:0]    sat_cnt,
  input  logic                  clr
);

  localparam logic [OUT_WIDTH-1:0] SMAX = OUT_WIDTH'(SAT_MAX(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] SMIN = OUT_WIDTH'(SAT_MIN(OUT_WIDTH));

  // Payload that travels alongside the valid bit; widths follow the parameters.
  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic [IDW-1:0]       id;
    logic                 sat;
  } sat_pay_t;

  logic [N-1:0]          grant;
  logic                  vld_in;
  logic [IN_WIDTH-1:0]   sel_word;
  logic [IDW-1:0]        sel_id;
  logic                  sel_ovf;
  sat_pay_t              pay_in;
  sat_pay_t              out_pay;

  rr_arb #(.N(N)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (en),
    .advance (vld_in),
    .grant   (grant)
  );

  // Grants are suppressed while reset is held so nothing is taken then.
  assign req_ready = grant & {N{~rst}};
  assign vld_in    = |(req_valid & req_ready);

  // Pick the accepted word (ready is one-hot) and its requester index.
  always_comb begin
    sel_word = '0;
    sel_id   = '0;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        sel_word = req_data[i*IN_WIDTH +: IN_WIDTH];
        sel_id   = IDW'(i);
      end
    end
  end

  // Narrow with saturation toward the sign of the original word.
  always_comb begin
    sel_ovf      = ovf_det(MAX_W'(sel_word), IN_WIDTH, OUT_WIDTH);
    pay_in.id    = sel_id;
    pay_in.sat   = sel_ovf;
    pay_in.data  = sel_word[OUT_WIDTH-1:0];
    if (sel_ovf) pay_in.data = sel_word[IN_WIDTH-1] ? SMIN : SMAX;
  end

  generate
    if (SAT_PIPE == 0) begin : g_nopipe
      assign out_valid = vld_in;
      assign out_pay   = pay_in;
    end else begin : g_pipe
      logic [SAT_PIPE:1] vld_pipe;
      sat_pay_t          pay_pipe [SAT_PIPE:1];

      // Valid shift register; reset drops any words in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[1] <= vld_in;
          for (int s = 2; s <= SAT_PIPE; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
      end

      // Payload follows the valid bit; contents are meaningless when invalid.
      always_ff @(posedge clk) begin
        pay_pipe[1] <= pay_in;
        for (int s = 2; s <= SAT_PIPE; s++) pay_pipe[s] <= pay_pipe[s-1];
      end

      assign out_valid = vld_pipe[SAT_PIPE];
      assign out_pay   = pay_pipe[SAT_PIPE];
    end
  endgenerate

  assign out_data = out_pay.data;
  assign out_id   = out_pay.id;
  assign out_sat  = out_pay.sat;

  generate
    for (genvar k = 0; k < N; k++) begin : g_stat
      logic             hit;
      logic             flag_q;
      logic [CNT_W-1:0] cnt_q;

      assign hit = out_valid & out_sat & (out_id == IDW'(k));

      // Sticky flag and non-wrapping count; clr wins over a same-cycle hit.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          flag_q <= 1'b0;
          cnt_q  <= '0;
        end else if (hit) begin
          flag_q <= 1'b1;
          if (~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign sat_flag[k]                = flag_q;
      assign sat_cnt[k*CNT_W +: CNT_W]  = cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_fix_sat_arb.sv
// Directed bench for fix_sat_arb at N=4, 16->8 bits, two pipeline stages.
module tb_fix_sat_arb;

  localparam int N = 4, IW = 16, OW = 8, SP = 2, CW = 4;

  logic              clk = 1'b0;
  logic              rst, en, clr;
  logic [N-1:0]      req_valid;
  logic [N*IW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic [OW-1:0]     out_data;
  logic [1:0]        out_id;
  logic              out_sat;
  logic [N-1:0]      sat_flag;
  logic [N*CW-1:0]   sat_cnt;

  int total = 0;
  int bad   = 0;

  fix_sat_arb #(.N(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SAT_PIPE(SP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_sat(out_sat), .sat_flag(sat_flag), .sat_cnt(sat_cnt), .clr(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] din;
    logic [OW-1:0] exp_data;
    logic          exp_sat;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{16'h007F, 8'h7F, 1'b0};
    vecs[1] = '{16'h0080, 8'h7F, 1'b1};
    vecs[2] = '{16'hFF80, 8'h80, 1'b0};
    vecs[3] = '{16'hFF7F, 8'h80, 1'b1};
    vecs[4] = '{16'h8000, 8'h80, 1'b1};
    vecs[5] = '{16'h7FFF, 8'h7F, 1'b1};
    vecs[6] = '{16'hFFFF, 8'hFF, 1'b0};
    vecs[7] = '{16'h0000, 8'h00, 1'b0};

    rst = 1'b1; en = 1'b1; clr = 1'b0; req_valid = '0; req_data = '0;
    step(); step();

    // Reset state: ready held low even with every requester valid.
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_sat_flag", 32'(sat_flag), 32'h0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'h0);

    // All requesting from reset: grants 0,1,2,3,... and ids lag by two.
    for (int i = 0; i < N; i++) req_data[i*IW +: IW] = 16'((i + 1) * 16);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      chk("all_grant", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        chk("all_out_valid", 32'(out_valid), 32'h1);
        chk("all_out_id", 32'(out_id), 32'((c - 2) % 4));
        chk("all_out_data", 32'(out_data), 32'(((c - 2) % 4 + 1) * 16));
      end
    end
    step();
    req_valid = '0;
    chk("all_tail_id2", 32'(out_id), 32'h2);
    step();
    chk("all_tail_id3", 32'(out_id), 32'h3);
    step();
    chk("all_drained", 32'(out_valid), 32'h0);

    // Single words from requester 2 through the boundary table.
    for (int v = 0; v < 8; v++) begin
      req_data[2*IW +: IW] = vecs[v].din;
      req_valid = 4'b0100;
      #1;
      chk("tbl_ready", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      step();
      chk("tbl_out_valid", 32'(out_valid), 32'h1);
      chk("tbl_out_data", 32'(out_data), 32'(vecs[v].exp_data));
      chk("tbl_out_id", 32'(out_id), 32'h2);
      chk("tbl_out_sat", 32'(out_sat), 32'(vecs[v].exp_sat));
    end
    step();
    chk("tbl_idle", 32'(out_valid), 32'h0);
    chk("tbl_cnt2", 32'(sat_cnt[2*CW +: CW]), 32'h4);
    chk("tbl_flag", 32'(sat_flag), 32'h4);
    chk("tbl_cnt0", 32'(sat_cnt[0 +: CW]), 32'h0);

    // Partial requesters 1 and 3, then a 3-cycle enable gap.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_data[1*IW +: IW] = 16'h0001;
    req_data[3*IW +: IW] = 16'h0003;
    req_valid = 4'b1010;
    #1;
    chk("part_g0", 32'(req_ready), 32'h2);
    step();
    chk("part_g1", 32'(req_ready), 32'h8);
    step();
    chk("part_g2", 32'(req_ready), 32'h2);
    chk("part_out_id_g0", 32'(out_id), 32'h1);
    step();
    en = 1'b0;
    #1;
    chk("en0_ready_a", 32'(req_ready), 32'h0);
    chk("en0_valid_a", 32'(out_valid), 32'h1);
    chk("en0_id_a", 32'(out_id), 32'h3);
    step();
    chk("en0_ready_b", 32'(req_ready), 32'h0);
    chk("en0_valid_b", 32'(out_valid), 32'h1);
    chk("en0_id_b", 32'(out_id), 32'h1);
    step();
    chk("en0_ready_c", 32'(req_ready), 32'h0);
    chk("en0_valid_c", 32'(out_valid), 32'h0);
    step();
    en = 1'b1;
    #1;
    chk("en1_resume", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;

    // Counter saturation: 20 overflowing words from requester 0.
    step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    req_data[0 +: IW] = 16'h1234;
    req_valid = 4'b0001;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      chk("cnt_ready", 32'(req_ready), 32'h1);
    end
    step();
    req_valid = '0;
    step(); step();
    chk("cnt_sat_max", 32'(sat_cnt[0 +: CW]), 32'hF);
    chk("cnt_flag0", 32'(sat_flag[0]), 32'h1);

    // clr coincident with a sat event drops it; the next event counts.
    req_valid = 4'b0001;
    step();
    step();
    req_valid = '0;
    clr = 1'b1;
    chk("clr_ev_valid", 32'(out_valid), 32'h1);
    chk("clr_ev_sat", 32'(out_sat), 32'h1);
    chk("clr_ev_id", 32'(out_id), 32'h0);
    step();
    clr = 1'b0;
    chk("clr_cnt", 32'(sat_cnt[0 +: CW]), 32'h0);
    chk("clr_flag", 32'(sat_flag), 32'h0);
    step();
    chk("post_clr_cnt", 32'(sat_cnt[0 +: CW]), 32'h1);
    chk("post_clr_flag", 32'(sat_flag), 32'h1);

    // Reset with two words in flight; pointer returns to 0.
    req_data[2*IW +: IW] = 16'h0100;
    req_valid = 4'b0100;
    #1;
    chk("mid_g_a", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0010;
    #1;
    chk("mid_g_b", 32'(req_ready), 32'h2);
    step();
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_after_grant", 32'(req_ready), 32'h1);
    chk("mid_after_valid_a", 32'(out_valid), 32'h0);
    chk("mid_after_cnt", 32'(sat_cnt), 32'h0);
    step();
    req_valid = '0;
    chk("mid_after_valid_b", 32'(out_valid), 32'h0);
    step();
    chk("mid_new_valid", 32'(out_valid), 32'h1);
    chk("mid_new_id", 32'(out_id), 32'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
